// File: rtl/txn_chk_pkg.sv
// Shared types for the constrained-transaction checker: kinds, violation bit indices
// and the buffered transaction record.
package txn_chk_pkg;

   // Field widths of the buffered record; the top-level ADDR_W/DATA_W must not exceed these.
   localparam int TXN_ADDR_W = 32;
   localparam int TXN_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RSVD  = 2'd3
   } kind_e;

   localparam int VIOL_RANGE = 0;
   localparam int VIOL_ALIGN = 1;
   localparam int VIOL_LEN   = 2;
   localparam int VIOL_KIND  = 3;

   typedef struct packed {
      kind_e                  kind;
      logic [TXN_ADDR_W-1:0]  addr;
      logic [TXN_DATA_W-1:0]  data;
      logic [3:0]             len;
   } txn_t;

endpackage

// File: rtl/txn_fifo.sv
// Synchronous FIFO of txn_t records with a registered full flag and a separate
// occupancy count so that wrapping pointers never alias full against empty.
module txn_fifo
   import txn_chk_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  txn_t                     wr_txn,
   input  logic                     pop,
   output txn_t                     rd_txn,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1'b1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   txn_t              mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W:0]    count_r;
   logic [PTR_W:0]    count_nxt_s;
   logic              full_r;
   logic              do_push_s;
   logic              do_pop_s;

   assign do_push_s = push && !full_r;
   assign do_pop_s  = pop && (count_r != '0);

   // Next occupancy: a simultaneous push and pop leaves the count unchanged.
   always_comb begin
      count_nxt_s = count_r;
      case ({do_push_s, do_pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointer, occupancy and full-flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         full_r   <= 1'b0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CNT_FULL);
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r] <= wr_txn;
   end

   assign rd_txn = mem_r[rd_ptr_r];
   assign full   = full_r;
   assign empty  = (count_r == '0);
   assign count  = count_r;

endmodule

// File: rtl/txn_checker.sv
// Transaction checker: buffers incoming transactions, classifies each one against the
// range/alignment/length/kind rules when it enters the output stage, and counts results.
module txn_checker
   import txn_chk_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] ADDR_LO    = '0,
   parameter logic [ADDR_W-1:0] ADDR_HI    = ADDR_W'(32'h0000_FFFF),
   parameter int                ALIGN_LOG2 = 2,
   parameter int                MAX_LEN    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_kind,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic [3:0]        in_len,
   input  logic [2:0]        layer_en,
   input  logic              clr_cnt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_kind,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic [3:0]        out_len,
   output logic [3:0]        out_viol,
   output logic [15:0]       accept_cnt,
   output logic [15:0]       reject_cnt
);

   localparam logic [3:0]  LEN_MAX_V = 4'(MAX_LEN);
   localparam logic [15:0] CNT_SAT   = 16'hFFFF;

   txn_t                       in_txn_s;
   txn_t                       head_s;
   logic                       fifo_full_s;
   logic                       fifo_empty_s;
   logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
   logic                       push_s;
   logic                       load_s;
   logic                       hs_s;
   logic [ADDR_W-1:0]          head_addr_s;
   logic [ADDR_W:0]            lo_diff_s;
   logic [3:0]                 viol_s;

   txn_t                       out_txn_r;
   logic                       out_valid_r;
   logic [3:0]                 out_viol_r;
   logic [15:0]                accept_cnt_r;
   logic [15:0]                reject_cnt_r;

   assign in_txn_s = '{kind: kind_e'(in_kind),
                       addr: TXN_ADDR_W'(in_addr),
                       data: TXN_DATA_W'(in_data),
                       len:  in_len};

   assign in_ready = !fifo_full_s;
   assign push_s   = in_valid && !fifo_full_s;
   assign hs_s     = out_valid_r && out_ready;
   assign load_s   = !fifo_empty_s && (!out_valid_r || out_ready);

   txn_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push_s),
      .wr_txn (in_txn_s),
      .pop    (load_s),
      .rd_txn (head_s),
      .full   (fifo_full_s),
      .empty  (fifo_empty_s),
      .count  (fifo_count_s)
   );

   // Lower bound uses the borrow of a subtraction so ADDR_LO == 0 is not a constant compare.
   assign head_addr_s = ADDR_W'(head_s.addr);
   assign lo_diff_s   = {1'b0, head_addr_s} - {1'b0, ADDR_LO};

   // Rule evaluation on the FIFO head; IDLE is exempt from the length rule, RSVD is never masked.
   always_comb begin
      viol_s             = 4'b0000;
      viol_s[VIOL_RANGE] = layer_en[0] && (lo_diff_s[ADDR_W] || (head_addr_s > ADDR_HI));
      viol_s[VIOL_ALIGN] = layer_en[1] && (head_addr_s[ALIGN_LOG2-1:0] != '0);
      viol_s[VIOL_LEN]   = layer_en[2] && (head_s.kind != IDLE) &&
                           ((head_s.len == 4'd0) || (head_s.len > LEN_MAX_V));
      viol_s[VIOL_KIND]  = (head_s.kind == RSVD);
   end

   // Output stage: load on empty or on handshake, hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_txn_r   <= '0;
         out_viol_r  <= 4'b0000;
      end else if (load_s) begin
         out_valid_r <= 1'b1;
         out_txn_r   <= head_s;
         out_viol_r  <= viol_s;
      end else if (hs_s) begin
         out_valid_r <= 1'b0;
      end
   end

   // Saturating result counters; a clear coincident with a handshake still counts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accept_cnt_r <= 16'd0;
         reject_cnt_r <= 16'd0;
      end else if (clr_cnt) begin
         accept_cnt_r <= (hs_s && (out_viol_r == 4'b0000)) ? 16'd1 : 16'd0;
         reject_cnt_r <= (hs_s && (out_viol_r != 4'b0000)) ? 16'd1 : 16'd0;
      end else if (hs_s) begin
         if (out_viol_r == 4'b0000) begin
            if (accept_cnt_r != CNT_SAT) accept_cnt_r <= accept_cnt_r + 16'd1;
         end else begin
            if (reject_cnt_r != CNT_SAT) reject_cnt_r <= reject_cnt_r + 16'd1;
         end
      end
   end

   assign out_valid  = out_valid_r;
   assign out_kind   = out_txn_r.kind;
   assign out_addr   = ADDR_W'(out_txn_r.addr);
   assign out_data   = DATA_W'(out_txn_r.data);
   assign out_len    = out_txn_r.len;
   assign out_viol   = out_viol_r;
   assign accept_cnt = accept_cnt_r;
   assign reject_cnt = reject_cnt_r;

endmodule

// File: tb/tb_txn_checker.sv
// Directed, table-driven bench for txn_checker: rule vectors plus hand-written
// stall/full, counter saturation/clear and mid-operation reset sequences.
module tb_txn_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_kind;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [3:0]  in_len;
   logic [2:0]  layer_en;
   logic        clr_cnt;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_kind;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   logic [3:0]  out_len;
   logic [3:0]  out_viol;
   logic [15:0] accept_cnt;
   logic [15:0] reject_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   txn_checker dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_addr(in_addr), .in_data(in_data), .in_len(in_len),
      .layer_en(layer_en), .clr_cnt(clr_cnt),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_kind(out_kind), .out_addr(out_addr), .out_data(out_data), .out_len(out_len),
      .out_viol(out_viol), .accept_cnt(accept_cnt), .reject_cnt(reject_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  kind;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [2:0]  en;
      logic [3:0]  viol;
   } vec_t;

   localparam int NV = 10;
   vec_t vec [NV];

   logic [31:0] s_addr [5];
   logic [31:0] s_data [5];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_counters();
      @(negedge clk);
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
   endtask

   initial begin
      vec[0] = '{kind: 2'd1, addr: 32'h0000_0100, len: 4'd4,  en: 3'b111, viol: 4'b0000};
      vec[1] = '{kind: 2'd2, addr: 32'h0001_0002, len: 4'd0,  en: 3'b111, viol: 4'b0111};
      vec[2] = '{kind: 2'd2, addr: 32'h0001_0002, len: 4'd0,  en: 3'b000, viol: 4'b0000};
      vec[3] = '{kind: 2'd0, addr: 32'h0000_0000, len: 4'd0,  en: 3'b111, viol: 4'b0000};
      vec[4] = '{kind: 2'd3, addr: 32'h0000_0100, len: 4'd4,  en: 3'b000, viol: 4'b1000};
      vec[5] = '{kind: 2'd1, addr: 32'h0000_FFFF, len: 4'd8,  en: 3'b111, viol: 4'b0010};
      vec[6] = '{kind: 2'd2, addr: 32'h0000_FFFC, len: 4'd9,  en: 3'b111, viol: 4'b0100};
      vec[7] = '{kind: 2'd1, addr: 32'h0000_FFFC, len: 4'd15, en: 3'b011, viol: 4'b0000};
      vec[8] = '{kind: 2'd2, addr: 32'h0001_0000, len: 4'd1,  en: 3'b001, viol: 4'b0001};
      vec[9] = '{kind: 2'd1, addr: 32'h0001_0000, len: 4'd1,  en: 3'b110, viol: 4'b0000};

      rst_n = 1'b0; in_valid = 1'b0; in_kind = 2'd0; in_addr = 32'd0; in_data = 32'd0;
      in_len = 4'd0; layer_en = 3'b111; clr_cnt = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_out_viol", out_viol, 0);
      chk("rst_accept", accept_cnt, 0);
      chk("rst_reject", reject_cnt, 0);

      // Rule vectors: push one, check latency, fields, then the handshake count.
      for (int i = 0; i < NV; i++) begin
         clear_counters();
         layer_en = vec[i].en;
         in_kind  = vec[i].kind;
         in_addr  = vec[i].addr;
         in_data  = 32'hA000_0000 + 32'(i);
         in_len   = vec[i].len;
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         chk($sformatf("v%0d_latency", i), out_valid, 0);
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), out_valid, 1);
         chk($sformatf("v%0d_viol", i), out_viol, vec[i].viol);
         chk($sformatf("v%0d_kind", i), out_kind, vec[i].kind);
         chk($sformatf("v%0d_addr", i), out_addr, vec[i].addr);
         chk($sformatf("v%0d_data", i), out_data, 32'hA000_0000 + 32'(i));
         chk($sformatf("v%0d_len", i), out_len, vec[i].len);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk($sformatf("v%0d_drained", i), out_valid, 0);
         chk($sformatf("v%0d_accept", i), accept_cnt, (vec[i].viol == 4'b0000) ? 1 : 0);
         chk($sformatf("v%0d_reject", i), reject_cnt, (vec[i].viol != 4'b0000) ? 1 : 0);
      end

      // Stall: five pushes fill output stage plus four FIFO entries, then in_ready drops.
      clear_counters();
      layer_en = 3'b111;
      for (int i = 0; i < 5; i++) begin
         s_addr[i] = 32'h0000_0200 + 32'(4 * i);
         s_data[i] = 32'h0000_00D0 + 32'(i);
      end
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         chk($sformatf("full_in_ready%0d", i), in_ready, (i < 5) ? 1 : 0);
         if (i < 5) begin
            in_valid = 1'b1;
            in_kind  = (i % 2 == 0) ? 2'd1 : 2'd2;
            in_addr  = s_addr[i];
            in_data  = s_data[i];
            in_len   = 4'd2;
         end else begin
            in_valid = 1'b0;
         end
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_addr", out_addr, s_addr[0]);
         chk("stall_data", out_data, s_data[0]);
         chk("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         if (j == 1) chk("full_release_ready", in_ready, 1);
         if (j < 5) begin
            chk($sformatf("order%0d_valid", j), out_valid, 1);
            chk($sformatf("order%0d_addr", j), out_addr, s_addr[j]);
            chk($sformatf("order%0d_data", j), out_data, s_data[j]);
         end else begin
            chk("order_empty", out_valid, 0);
         end
      end
      out_ready = 1'b0;
      chk("stall_accept", accept_cnt, 5);

      // Saturation: sustained legal traffic well past 65535 handshakes.
      clear_counters();
      in_kind = 2'd1; in_addr = 32'h0000_0040; in_data = 32'h1234_5678; in_len = 4'd1;
      in_valid = 1'b1; out_ready = 1'b1;
      repeat (65545) @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("sat_accept", accept_cnt, 16'hFFFF);
      chk("sat_reject", reject_cnt, 0);
      out_ready = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("clr_hs_valid", out_valid, 1);
      out_ready = 1'b1;
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      out_ready = 1'b0;
      chk("clr_hs_accept", accept_cnt, 1);
      chk("clr_hs_reject", reject_cnt, 0);

      // Mid-operation reset with buffered entries.
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_addr  = 32'h0000_0500 + 32'(4 * i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_valid", out_valid, 0);
      chk("rst_async_ready", in_ready, 1);
      chk("rst_async_accept", accept_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("no_stale%0d", k), out_valid, 0);
      end
      in_valid = 1'b1;
      in_addr  = 32'h0000_0300;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_addr", out_addr, 32'h0000_0300);
      @(negedge clk);
      chk("post_rst_drain", out_valid, 0);
      @(negedge clk);
      chk("post_rst_idle", out_valid, 0);
      chk("post_rst_accept", accept_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
